// File: rtl/fpnew_issue_pkg.sv
// Shared types for the FPNew issue/reorder front end: FPU operation fields,
// reorder-buffer entry layout and the issue FSM state encoding.
package fpnew_issue_pkg;

    localparam int unsigned ROB_FLEN = 64;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        DYN = 3'b111
    } roundmode_e;

    typedef enum logic [3:0] {
        FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
        CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
    } operation_e;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    typedef enum logic [1:0] {
        INT8, INT16, INT32, INT64
    } int_format_e;

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

    typedef struct packed {
        logic [ROB_FLEN-1:0] result;
        status_t             status;
        logic                done;
    } rob_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_e;

endpackage

// File: rtl/fpnew_issue_rob_mem.sv
// Reorder-buffer storage: one write port addressed by the FPU tag, one read
// port at the retire pointer, per-entry done bits with bulk clear on flush.
module fpnew_issue_rob_mem
    import fpnew_issue_pkg::*;
#(
    parameter int unsigned TAG_WIDTH = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_all_i,
    input  logic                      we_i,
    input  logic [TAG_WIDTH-1:0]      waddr_i,
    input  logic [ROB_FLEN-1:0]       wresult_i,
    input  status_t                   wstatus_i,
    input  logic                      clr_i,
    input  logic [TAG_WIDTH-1:0]      raddr_i,
    output rob_entry_t                rdata_o,
    output logic [2**TAG_WIDTH-1:0]   done_o
);

    localparam int unsigned DEPTH = 2**TAG_WIDTH;

    rob_entry_t mem_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear_all_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i].done <= 1'b0;
            end
        end else begin
            // Write and retire never target the same entry in one cycle.
            if (we_i) begin
                mem_q[waddr_i] <= '{result: wresult_i, status: wstatus_i, done: 1'b1};
            end
            if (clr_i) begin
                mem_q[raddr_i].done <= 1'b0;
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

    for (genvar g = 0; g < DEPTH; g++) begin : g_done
        assign done_o[g] = mem_q[g].done;
    end

endmodule

// File: rtl/fpnew_issue_rob.sv
// Issues tagged FP commands to one FPNew instance and returns the tagged,
// possibly out-of-order results to the client in issue order; flush drains.
module fpnew_issue_rob
    import fpnew_issue_pkg::*;
#(
    parameter int unsigned FLEN      = 64,
    parameter int unsigned TAG_WIDTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [3*FLEN-1:0]     cmd_operands_i,
    input  roundmode_e            cmd_rnd_mode_i,
    input  operation_e            cmd_op_i,
    input  logic                  cmd_op_mod_i,
    input  fp_format_e            cmd_src_fmt_i,
    input  fp_format_e            cmd_dst_fmt_i,
    input  int_format_e           cmd_int_fmt_i,
    input  logic                  cmd_vectorial_op_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [FLEN-1:0]       rsp_result_o,
    output status_t               rsp_status_o,
    output logic [3*FLEN-1:0]     fpu_operands_o,
    output roundmode_e            fpu_rnd_mode_o,
    output operation_e            fpu_op_o,
    output logic                  fpu_op_mod_o,
    output fp_format_e            fpu_src_fmt_o,
    output fp_format_e            fpu_dst_fmt_o,
    output int_format_e           fpu_int_fmt_o,
    output logic                  fpu_vectorial_op_o,
    output logic [TAG_WIDTH-1:0]  fpu_tag_o,
    output logic                  fpu_in_valid_o,
    input  logic                  fpu_in_ready_i,
    output logic                  fpu_flush_o,
    input  logic [FLEN-1:0]       fpu_result_i,
    input  status_t               fpu_status_i,
    input  logic [TAG_WIDTH-1:0]  fpu_tag_i,
    input  logic                  fpu_out_valid_i,
    output logic                  fpu_out_ready_o,
    input  logic                  fpu_busy_i,
    output logic                  err_o
);

    localparam int unsigned DEPTH = 2**TAG_WIDTH;
    localparam int unsigned CW    = TAG_WIDTH + 1;

    state_e                state_q, state_d;
    logic [TAG_WIDTH-1:0]  issue_ptr_q, issue_ptr_d;
    logic [TAG_WIDTH-1:0]  retire_ptr_q, retire_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  err_q, err_d;

    logic                  issue, retire, wr_en, clear_all;
    logic                  slot_free, tag_live;
    logic [TAG_WIDTH-1:0]  tag_off;
    logic [DEPTH-1:0]      done_vec;
    rob_entry_t            head;

    assign slot_free = count_q < CW'(DEPTH);
    // A returning tag is live if it lies within [retire_ptr, retire_ptr + count).
    assign tag_off   = fpu_tag_i - retire_ptr_q;
    assign tag_live  = {1'b0, tag_off} < count_q;

    always_comb begin
        state_d        = state_q;
        issue          = 1'b0;
        retire         = 1'b0;
        wr_en          = 1'b0;
        clear_all      = 1'b0;
        err_d          = err_q;
        cmd_ready_o    = 1'b0;
        fpu_in_valid_o = 1'b0;
        rsp_valid_o    = 1'b0;
        fpu_flush_o    = 1'b0;
        unique case (state_q)
            RUN: begin
                if (flush_i) begin
                    fpu_flush_o = 1'b1;
                    clear_all   = 1'b1;
                    state_d     = DRAIN;
                end else begin
                    fpu_in_valid_o = cmd_valid_i & slot_free;
                    cmd_ready_o    = fpu_in_ready_i & slot_free;
                    issue          = cmd_valid_i & cmd_ready_o;
                    rsp_valid_o    = head.done;
                    retire         = rsp_valid_o & rsp_ready_i;
                    if (fpu_out_valid_i) begin
                        if (tag_live && !done_vec[fpu_tag_i]) begin
                            wr_en = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            DRAIN: begin
                fpu_flush_o = flush_i;
                if (!flush_i && !fpu_busy_i) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        issue_ptr_d  = issue_ptr_q + TAG_WIDTH'(issue);
        retire_ptr_d = retire_ptr_q + TAG_WIDTH'(retire);
        count_d      = count_q;
        unique case ({issue, retire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (clear_all) begin
            issue_ptr_d  = '0;
            retire_ptr_d = '0;
            count_d      = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= RUN;
            issue_ptr_q  <= '0;
            retire_ptr_q <= '0;
            count_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            issue_ptr_q  <= issue_ptr_d;
            retire_ptr_q <= retire_ptr_d;
            count_q      <= count_d;
            err_q        <= err_d;
        end
    end

    fpnew_issue_rob_mem #(
        .TAG_WIDTH (TAG_WIDTH)
    ) i_mem (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_all_i (clear_all),
        .we_i        (wr_en),
        .waddr_i     (fpu_tag_i),
        .wresult_i   (ROB_FLEN'(fpu_result_i)),
        .wstatus_i   (fpu_status_i),
        .clr_i       (retire),
        .raddr_i     (retire_ptr_q),
        .rdata_o     (head),
        .done_o      (done_vec)
    );

    assign rsp_result_o       = FLEN'(head.result);
    assign rsp_status_o       = head.status;
    assign err_o              = err_q;
    assign fpu_out_ready_o    = 1'b1;
    assign fpu_tag_o          = issue_ptr_q;
    assign fpu_operands_o     = cmd_operands_i;
    assign fpu_rnd_mode_o     = cmd_rnd_mode_i;
    assign fpu_op_o           = cmd_op_i;
    assign fpu_op_mod_o       = cmd_op_mod_i;
    assign fpu_src_fmt_o      = cmd_src_fmt_i;
    assign fpu_dst_fmt_o      = cmd_dst_fmt_i;
    assign fpu_int_fmt_o      = cmd_int_fmt_i;
    assign fpu_vectorial_op_o = cmd_vectorial_op_i;

endmodule
